seq_alu: RTL and testbench

Multi-cycle, parametrised integer ALU for the pipelined CPU's EX stage, replacing the purely combinational ALU. Single-cycle logic and arithmetic ops return after one registered cycle. Multiply runs on an iterative shift-add engine; optional divide/remainder runs on an iterative restoring engine. A valid/ready handshake on both sides lets the hazard unit stall the pipeline while a long op is in flight.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_alu_muldiv.sv | 105 ++++++++++
 rtl/seq_alu.sv | 115 +++++++++++
 tb/tb_seq_alu.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Purpose : shared opcodes, FSM state type and op-class helper for seq_alu.
// Latency : n/a (declarations only).
// Backpressure: n/a. Build option SEQ_ALU_DIV_EN routes DIV/REM to the divider.
package seq_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;
  localparam logic [3:0] ALU_DIV = 4'b1000;
  localparam logic [3:0] ALU_REM = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // True for opcodes that run on the iterative engine. Without the divider,
  // DIV/REM fall through to the single-cycle path as undefined opcodes.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REM);
`else
    return (op == ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Purpose : request/result bundle between the EX-stage issue logic and seq_alu.
// Latency : n/a (wires only).
// Backpressure: valid_i/ready_o on the request side, valid_o/ready_i on the result side.
// Signals: valid_i, data1_i, data2_i, ALUCtrl_i, ready_i driven by the master;
//          ready_o, valid_o, data_o, Zero_o, busy_o driven by the ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [3:0]       ALUCtrl_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             Zero_o;
  logic             busy_o;

  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    input  ready_o, valid_o, data_o, Zero_o, busy_o
  );

  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    output ready_o, valid_o, data_o, Zero_o, busy_o
  );

endinterface

// File: rtl/seq_alu_muldiv.sv
// Purpose : iterative shift-add multiplier and (with SEQ_ALU_DIV_EN) restoring divider.
// Latency : WIDTH cycles from start_i; done_o is high in the last iteration cycle.
// Backpressure: none; the caller only pulses start_i while the engine is idle.
// Ports: clk_i, rst_n_i, start_i, op_i (ALU opcode), a_i/b_i (operands),
//        done_o (final iteration this cycle), result_o (valid while done_o).
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  // Shared registers:
  //   MUL: acc = partial product, opa = multiplicand (shifts left),
  //        opb = multiplier (shifts right).
  //   DIV: acc = partial remainder, opa = divisor,
  //        opb = dividend shifting out / quotient shifting in.
  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [WIDTH-1:0] acc_d, opa_d, opb_d;
  logic [WIDTH-1:0] mul_acc;

`ifdef SEQ_ALU_DIV_EN
  logic             div_q;
  logic             rem_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             start_div;

  assign start_div = (op_i == ALU_DIV) || (op_i == ALU_REM);
`else
  logic unused_op;
  assign unused_op = ^op_i;
`endif

  always_comb begin
    mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
    acc_d   = mul_acc;
    opa_d   = opa_q << 1;
    opb_d   = opb_q >> 1;
    result_o = mul_acc;
`ifdef SEQ_ALU_DIV_EN
    // Restoring step: bring in the next dividend bit and try the subtract.
    // The top bit of diff is the borrow; a zero divisor never borrows, so
    // the quotient saturates to all-ones and the remainder ends as the dividend.
    shifted = {acc_q, opb_q[WIDTH-1]};
    diff    = shifted - {1'b0, opa_q};
    if (div_q) begin
      acc_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      opa_d = opa_q;
      opb_d = {opb_q[WIDTH-2:0], ~diff[WIDTH]};
      result_o = rem_q ? acc_d : opb_d;
    end
`endif
  end

  assign done_o = run_q && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
      rem_q <= 1'b0;
`endif
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= CNT_W'(WIDTH - 1);
      acc_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= start_div;
      rem_q <= (op_i == ALU_REM);
      opa_q <= start_div ? b_i : a_i;
      opb_q <= start_div ? a_i : b_i;
`else
      opa_q <= a_i;
      opb_q <= b_i;
`endif
    end else if (run_q) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Purpose : multi-cycle EX-stage ALU: single-cycle logic/arith, iterative MUL (+DIV/REM with SEQ_ALU_DIV_EN).
// Latency : single-cycle ops: result after the accepting edge; MUL/DIV/REM: WIDTH cycles later.
// Backpressure: ready_o drops while BUSY or while a result waits in DONE with ready_i low.
// Ports: clk_i, rst_n_i (async, active low), alu (seq_alu_if.slave): request
//        valid_i/ready_o/data1_i/data2_i/ALUCtrl_i, result valid_o/ready_i/data_o/Zero_o, busy_o.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  seq_alu_if.slave  alu
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;

  logic             ready;
  logic             accept;
  logic             iter_op;
  logic             eng_start;
  logic             eng_done;
  logic [WIDTH-1:0] eng_result;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] res_d;
  logic             load_res;

  // A draining result may be replaced in the same cycle it is consumed,
  // which gives back-to-back issue with no bubble.
  assign ready   = (state_q == IDLE) || ((state_q == DONE) && alu.ready_i);
  assign accept  = alu.valid_i && ready;
  assign iter_op = is_iter_op(alu.ALUCtrl_i);

  always_comb begin
    single_res = '0;
    case (alu.ALUCtrl_i)
      ALU_ADD: single_res = alu.data1_i + alu.data2_i;
      ALU_SUB: single_res = alu.data1_i - alu.data2_i;
      ALU_AND: single_res = alu.data1_i & alu.data2_i;
      ALU_OR:  single_res = alu.data1_i | alu.data2_i;
      ALU_XOR: single_res = alu.data1_i ^ alu.data2_i;
      ALU_SLT: single_res = {{(WIDTH-1){1'b0}},
                             ($signed(alu.data1_i) < $signed(alu.data2_i))};
      // Without the divider these are plain undefined opcodes.
      ALU_DIV, ALU_REM: single_res = '0;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    load_res  = 1'b0;
    res_d     = single_res;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (iter_op) begin
            eng_start = 1'b1;
            state_d   = BUSY;
          end else begin
            load_res  = 1'b1;
            state_d   = DONE;
          end
        end else if ((state_q == DONE) && alu.ready_i) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (eng_done) begin
          load_res = 1'b1;
          res_d    = eng_result;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (load_res) begin
        data_q <= res_d;
        zero_q <= (res_d == '0);
      end
    end
  end

  seq_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (eng_start),
    .op_i     (alu.ALUCtrl_i),
    .a_i      (alu.data1_i),
    .b_i      (alu.data2_i),
    .done_o   (eng_done),
    .result_o (eng_result)
  );

  assign alu.ready_o = ready;
  assign alu.valid_o = (state_q == DONE);
  assign alu.busy_o  = (state_q == BUSY);
  assign alu.data_o  = data_q;
  assign alu.Zero_o  = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Purpose : self-checking bench for seq_alu (WIDTH = 32), table vectors plus multi-cycle sequences.
// Latency : n/a.
// Backpressure: exercises ready_i low in DONE and requests held during BUSY. Honors SEQ_ALU_DIV_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .alu     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that samples the request.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(posedge clk); #1;
    bus.valid_i   = 1'b0;
  endtask

  // Number of further edges until valid_o, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_cnt;
    int rdy_bad;
    int seen_valid;

    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.ALUCtrl_i = 4'b0000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;

    add_vec(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    add_vec(ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    add_vec(ALU_SLT, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_0001, 0);
    add_vec(ALU_SLT, 32'h0000_0002, 32'hFFFF_FFFD, 32'h0000_0000, 0);
    add_vec(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
    add_vec(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
    add_vec(ALU_OR,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0);
    add_vec(ALU_XOR, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_FF00, 0);
    add_vec(ALU_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 0);
    add_vec(4'b0101, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 0);
    add_vec(ALU_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, W);
    add_vec(ALU_MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, W);
    add_vec(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, W);
    add_vec(ALU_MUL, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, W);
    add_vec(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
`ifdef SEQ_ALU_DIV_EN
    add_vec(ALU_DIV, 32'd100, 32'd7, 32'd14, W);
    add_vec(ALU_REM, 32'd100, 32'd7, 32'd2, W);
    add_vec(ALU_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, W);
    add_vec(ALU_REM, 32'd9, 32'd0, 32'd9, W);
    add_vec(ALU_DIV, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, W);
`else
    add_vec(ALU_DIV, 32'd100, 32'd7, 32'd0, 0);
    add_vec(ALU_REM, 32'd100, 32'd7, 32'd0, 0);
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", bus.ready_o, 1);
    check("rst_valid", bus.valid_o, 0);
    check("rst_data",  bus.data_o, 0);
    check("rst_zero",  bus.Zero_o, 1);
    check("rst_busy",  bus.busy_o, 0);

    // Table vectors, issued back to back while ready_i stays high.
    foreach (vecs[i]) begin
      check($sformatf("v%0d_ready", i), bus.ready_o, 1);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_data", i), bus.data_o, vecs[i].exp);
      check($sformatf("v%0d_zero", i), bus.Zero_o, (vecs[i].exp == '0));
    end

    // MUL with a second request held during BUSY: ready_o stays low for
    // the whole iteration, and the held ADD is taken as the MUL drains.
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i   = 32'd3;
    bus.data2_i   = 32'd5;
    @(posedge clk); #1;
    bus.ALUCtrl_i = ALU_ADD;
    bus.data1_i   = 32'd1;
    bus.data2_i   = 32'd1;
    busy_cnt = 0;
    rdy_bad  = 0;
    while (bus.busy_o && busy_cnt < 100) begin
      busy_cnt++;
      if (bus.ready_o) rdy_bad++;
      @(posedge clk); #1;
    end
    check("mul_busy_cycles", busy_cnt, W);
    check("mul_ready_in_busy", rdy_bad, 0);
    check("mul_valid", bus.valid_o, 1);
    check("mul_data", bus.data_o, 32'd15);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    check("held_add_valid", bus.valid_o, 1);
    check("held_add_data", bus.data_o, 32'd2);
    @(posedge clk); #1;
    check("drain_idle_valid", bus.valid_o, 0);

    // Reset during iteration 10 of a MUL aborts it.
    issue(ALU_MUL, 32'h0001_0000, 32'h0001_0001);
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy_o, 0);
    check("abort_valid", bus.valid_o, 0);
    check("abort_ready", bus.ready_o, 1);
    check("abort_zero", bus.Zero_o, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    seen_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.valid_o || bus.busy_o) seen_valid++;
      @(posedge clk); #1;
    end
    check("abort_no_result", seen_valid, 0);

    // Result held in DONE with ready_i low; a pending SUB must wait.
    bus.ready_i = 1'b0;
    issue(ALU_ADD, 32'd3, 32'd4);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = ALU_SUB;
    bus.data1_i   = 32'd10;
    bus.data2_i   = 32'd4;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), bus.valid_o, 1);
      check($sformatf("hold%0d_data", k), bus.data_o, 32'd7);
      check($sformatf("hold%0d_ready", k), bus.ready_o, 0);
      @(posedge clk); #1;
    end
    bus.ready_i = 1'b1;
    #1;
    check("release_ready", bus.ready_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    check("release_sub_valid", bus.valid_o, 1);
    check("release_sub_data", bus.data_o, 32'd6);
    check("release_sub_zero", bus.Zero_o, 0);
    @(posedge clk); #1;
    check("final_idle", bus.valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
